// File: rtl/sbox_port_scheduler.sv
// Streams a 128-bit masked state through a dual-port S-box RAM, two bytes per
// cycle, and reassembles the substituted bytes once the RAM read latency has passed.
module sbox_port_scheduler #(
  parameter int unsigned RD_LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   tsel,
  input  logic [127:0] state_in,
  output logic         ready,
  output logic [9:0]   bram_addra,
  output logic [9:0]   bram_addrb,
  output logic         bram_en,
  output logic         bram_rst,
  input  logic [7:0]   bram_doa,
  input  logic [7:0]   bram_dob,
  output logic [127:0] state_out,
  output logic         done
);

  localparam int unsigned KW = 3;
  localparam int unsigned CW = 2;
  localparam int unsigned AW = 10;
  localparam int unsigned SW = 128;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [CW-1:0]     dcnt_q, dcnt_d;
  logic [1:0]        tsel_q, tsel_d;
  logic [SW-1:0]     sin_q, sin_d;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [KW-1:0]     idx_q [RD_LAT];
  logic [KW-1:0]     idx_d [RD_LAT];
  logic [SW-1:0]     sout_q, sout_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              en_q, en_d;
  logic [AW-1:0]     addra_q, addra_d;
  logic [AW-1:0]     addrb_q, addrb_d;
  logic [15:0]       pair;

  // Job sequencing: 8 issue cycles, RD_LAT drain cycles, one done cycle.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    dcnt_d  = dcnt_q;
    tsel_d  = tsel_q;
    sin_d   = sin_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          k_d     = '0;
          tsel_d  = tsel;
          sin_d   = state_in;
        end
      end
      S_ISSUE: begin
        if (k_q == KW'(7)) begin
          state_d = S_DRAIN;
          dcnt_d  = '0;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_DRAIN: begin
        if (dcnt_q == CW'(RD_LAT - 1)) begin
          state_d = S_DONE;
        end else begin
          dcnt_d = dcnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from next-state so they line up with state_q.
  always_comb begin
    pair    = sin_d[{k_d, 4'b0000} +: 16];
    addra_d = '0;
    addrb_d = '0;
    if (state_d == S_ISSUE) begin
      addra_d = {tsel_d, pair[7:0]};
      addrb_d = {tsel_d, pair[15:8]};
    end
    en_d    = (state_d == S_ISSUE) || (state_d == S_DRAIN);
    ready_d = (state_d == S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  // Delay line pairs each issued byte pair with the RAM data RD_LAT cycles later.
  always_comb begin
    vld_d    = '0;
    idx_d    = idx_q;
    vld_d[0] = (state_q == S_ISSUE);
    idx_d[0] = k_q;
    for (int i = 1; i < int'(RD_LAT); i++) begin
      vld_d[i] = vld_q[i-1];
      idx_d[i] = idx_q[i-1];
    end
    sout_d = sout_q;
    if (vld_q[RD_LAT-1]) begin
      sout_d[{idx_q[RD_LAT-1], 4'b0000} +: 16] = {bram_dob, bram_doa};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      dcnt_q  <= '0;
      tsel_q  <= '0;
      sin_q   <= '0;
      vld_q   <= '0;
      idx_q   <= '{default: '0};
      sout_q  <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      en_q    <= 1'b0;
      addra_q <= '0;
      addrb_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      dcnt_q  <= dcnt_d;
      tsel_q  <= tsel_d;
      sin_q   <= sin_d;
      vld_q   <= vld_d;
      idx_q   <= idx_d;
      sout_q  <= sout_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      en_q    <= en_d;
      addra_q <= addra_d;
      addrb_q <= addrb_d;
    end
  end

  assign ready      = ready_q;
  assign done       = done_q;
  assign bram_en    = en_q;
  assign bram_addra = addra_q;
  assign bram_addrb = addrb_q;
  assign state_out  = sout_q;
  // RAM output registers are held in reset whenever the scheduler is.
  assign bram_rst   = ~rst;

endmodule
